// File: rtl/dm_acc_ctl.sv
// ----------------------------------------------------------------------------
// dm_acc_ctl
//
// Data-memory access controller between the data address generator and a
// single-port data memory that may insert wait states. A read or write
// command from the program sequencer is registered onto the memory
// interface. The sequencer is stalled while the memory reports not-ready.
// Read data is returned to the bus-connect path. An access that stays
// not-ready for TMO+1 consecutive cycles is aborted with an error pulse.
//
// Ports
//   clk_rf      in   clock, all state changes on the rising edge
//   rst_n       in   asynchronous active-low reset
//   ps_dm_rd    in   sequencer read command (sampled while not stalled)
//   ps_dm_wrt   in   sequencer write command (sampled while not stalled)
//   dg_dm_add   in   [15:0] address from the DAG, valid with the command
//   bc_dt       in   [15:0] write data from bus connect, valid with write
//   dm_rdy      in   memory ready; a pending access completes when 1
//   dm_rd_dt    in   [15:0] memory read data, valid with dm_rdy on a read
//   dm_add      out  [15:0] registered memory address
//   dm_wrt_dt   out  [15:0] registered memory write data
//   dm_rd_en    out  registered read strobe
//   dm_wrt_en   out  registered write strobe
//   dm_bc_dt    out  [15:0] read data to bus connect, held between reads
//   dm_bc_vld   out  one-cycle pulse when dm_bc_dt is updated
//   dm_ps_stall out  sequencer stall (combinational)
//   dm_err      out  one-cycle error pulse (timeout or illegal command)
// ----------------------------------------------------------------------------
module dm_acc_ctl #(
    parameter int TMO = 15
) (
    input  logic        clk_rf,
    input  logic        rst_n,
    input  logic        ps_dm_rd,
    input  logic        ps_dm_wrt,
    input  logic [15:0] dg_dm_add,
    input  logic [15:0] bc_dt,
    input  logic        dm_rdy,
    input  logic [15:0] dm_rd_dt,
    output logic [15:0] dm_add,
    output logic [15:0] dm_wrt_dt,
    output logic        dm_rd_en,
    output logic        dm_wrt_en,
    output logic [15:0] dm_bc_dt,
    output logic        dm_bc_vld,
    output logic        dm_ps_stall,
    output logic        dm_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam logic [3:0] WCNT_MAX = 4'(TMO);

    state_t     state;
    logic       op_rd;      // 1: pending access is a read, 0: a write
    logic [3:0] wcnt;       // consecutive not-ready cycles of the pending access

    logic cmd_legal;
    logic cmd_illegal;
    logic accept;
    logic rd_done;

    // Stall only while an access is pending and the memory is not ready.
    assign dm_ps_stall = (state == ST_REQ) && !dm_rdy;

    // Commands are only looked at while the sequencer is not stalled.
    assign cmd_legal   = !dm_ps_stall && (ps_dm_rd ^ ps_dm_wrt);
    assign cmd_illegal = !dm_ps_stall && ps_dm_rd && ps_dm_wrt;

    // A legal command is taken from IDLE or from a completing REQ cycle;
    // in REQ with dm_rdy=0 the stall already masks it.
    assign accept  = cmd_legal;
    assign rd_done = (state == ST_REQ) && dm_rdy && op_rd;

    always_ff @(posedge clk_rf or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_rd     <= 1'b0;
            wcnt      <= 4'd0;
            dm_add    <= 16'h0000;
            dm_wrt_dt <= 16'h0000;
            dm_rd_en  <= 1'b0;
            dm_wrt_en <= 1'b0;
            dm_bc_dt  <= 16'h0000;
            dm_bc_vld <= 1'b0;
            dm_err    <= 1'b0;
        end else begin
            dm_bc_vld <= 1'b0;
            dm_err    <= 1'b0;

            // Returning read data is independent of whether a new command
            // is taken in the same cycle (back-to-back reads).
            if (rd_done) begin
                dm_bc_dt  <= dm_rd_dt;
                dm_bc_vld <= 1'b1;
            end

            if (accept) begin
                state     <= ST_REQ;
                op_rd     <= ps_dm_rd;
                wcnt      <= 4'd0;
                dm_add    <= dg_dm_add;
                dm_rd_en  <= ps_dm_rd;
                dm_wrt_en <= ps_dm_wrt;
                if (ps_dm_wrt) begin
                    dm_wrt_dt <= bc_dt;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        dm_rd_en  <= 1'b0;
                        dm_wrt_en <= 1'b0;
                        dm_err    <= cmd_illegal;
                    end
                    ST_REQ: begin
                        if (dm_rdy) begin
                            // Completion with no follow-on command
                            // (possibly an illegal one).
                            state     <= ST_IDLE;
                            dm_rd_en  <= 1'b0;
                            dm_wrt_en <= 1'b0;
                            dm_err    <= cmd_illegal;
                        end else if (wcnt == WCNT_MAX) begin
                            // Timeout abort: an aborted read still hands
                            // zero data back so the consumer is not left
                            // waiting.
                            state     <= ST_IDLE;
                            dm_rd_en  <= 1'b0;
                            dm_wrt_en <= 1'b0;
                            dm_err    <= 1'b1;
                            if (op_rd) begin
                                dm_bc_dt  <= 16'h0000;
                                dm_bc_vld <= 1'b1;
                            end
                        end else begin
                            wcnt <= wcnt + 4'd1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dm_acc_ctl.sv
// ----------------------------------------------------------------------------
// tb_dm_acc_ctl
//
// Directed and randomized access sequences for dm_acc_ctl. Each access is
// described at transaction level (op, address, data, number of wait
// states). The expected strobe length, stall length, completion or abort
// outcome and returned data are derived from those parameters alone.
// ----------------------------------------------------------------------------
module tb_dm_acc_ctl;

    localparam int TMO = 15;

    logic        clk_rf = 1'b0;
    logic        rst_n;
    logic        ps_dm_rd;
    logic        ps_dm_wrt;
    logic [15:0] dg_dm_add;
    logic [15:0] bc_dt;
    logic        dm_rdy;
    logic [15:0] dm_rd_dt;
    logic [15:0] dm_add;
    logic [15:0] dm_wrt_dt;
    logic        dm_rd_en;
    logic        dm_wrt_en;
    logic [15:0] dm_bc_dt;
    logic        dm_bc_vld;
    logic        dm_ps_stall;
    logic        dm_err;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference state: last value handed to bus connect, last write data.
    logic [15:0] exp_bc_dt  = 16'h0000;
    logic [15:0] exp_wrt_dt = 16'h0000;

    always #5 clk_rf = ~clk_rf;

    dm_acc_ctl #(.TMO(TMO)) dut (
        .clk_rf      (clk_rf),
        .rst_n       (rst_n),
        .ps_dm_rd    (ps_dm_rd),
        .ps_dm_wrt   (ps_dm_wrt),
        .dg_dm_add   (dg_dm_add),
        .bc_dt       (bc_dt),
        .dm_rdy      (dm_rdy),
        .dm_rd_dt    (dm_rd_dt),
        .dm_add      (dm_add),
        .dm_wrt_dt   (dm_wrt_dt),
        .dm_rd_en    (dm_rd_en),
        .dm_wrt_en   (dm_wrt_en),
        .dm_bc_dt    (dm_bc_dt),
        .dm_bc_vld   (dm_bc_vld),
        .dm_ps_stall (dm_ps_stall),
        .dm_err      (dm_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_rf);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_add"},   dm_add,      16'h0000);
        chk({tag, "_wdt"},   dm_wrt_dt,   16'h0000);
        chk({tag, "_rden"},  dm_rd_en,    1'b0);
        chk({tag, "_wren"},  dm_wrt_en,   1'b0);
        chk({tag, "_bcdt"},  dm_bc_dt,    16'h0000);
        chk({tag, "_vld"},   dm_bc_vld,   1'b0);
        chk({tag, "_stall"}, dm_ps_stall, 1'b0);
        chk({tag, "_err"},   dm_err,      1'b0);
    endtask

    // One isolated access starting and ending in IDLE. n_wait is the
    // number of not-ready cycles before the memory reports ready; any
    // value above TMO means the memory never answers.
    task automatic run_access(input bit is_rd, input logic [15:0] addr,
                              input logic [15:0] data, input int n_wait);
        bit completes;
        int n_req;
        int exp_stall;
        int n_strobe;
        int n_stall;
        completes = (n_wait <= TMO);
        n_req     = completes ? n_wait + 1 : TMO + 1;
        exp_stall = completes ? n_wait : TMO + 1;
        n_strobe  = 0;
        n_stall   = 0;

        $display("txn %s addr=%h data=%h waits=%0d", is_rd ? "rd" : "wr", addr, data, n_wait);

        ps_dm_rd  = is_rd;
        ps_dm_wrt = !is_rd;
        dg_dm_add = addr;
        bc_dt     = is_rd ? ~data : data;
        dm_rd_dt  = is_rd ? data : ~data;
        dm_rdy    = 1'b0;
        #1;
        chk("idle_stall", dm_ps_stall, 1'b0);
        tick();
        if (!is_rd) exp_wrt_dt = data;

        for (int k = 1; k <= n_req; k++) begin
            chk("req_add", dm_add, addr);
            chk("req_wdt", dm_wrt_dt, exp_wrt_dt);
            chk("req_other_strobe", is_rd ? dm_wrt_en : dm_rd_en, 1'b0);
            chk("req_vld", dm_bc_vld, 1'b0);
            chk("req_err", dm_err, 1'b0);
            n_strobe += int'(is_rd ? dm_rd_en : dm_wrt_en);
            ps_dm_rd  = 1'b0;
            ps_dm_wrt = 1'b0;
            dm_rdy    = completes && (k > n_wait);
            #1;
            n_stall += int'(dm_ps_stall);
            tick();
        end

        if (is_rd) exp_bc_dt = completes ? data : 16'h0000;
        dm_rdy = 1'b0;
        #1;
        chk("strobe_cycles", 16'(n_strobe), 16'(n_req));
        chk("stall_cycles",  16'(n_stall),  16'(exp_stall));
        chk("end_rden",  dm_rd_en,    1'b0);
        chk("end_wren",  dm_wrt_en,   1'b0);
        chk("end_stall", dm_ps_stall, 1'b0);
        chk("end_vld",   dm_bc_vld,   is_rd);
        chk("end_err",   dm_err,      !completes);
        chk("end_bcdt",  dm_bc_dt,    exp_bc_dt);
        chk("end_wdt",   dm_wrt_dt,   exp_wrt_dt);
        tick();
        chk("post_vld", dm_bc_vld, 1'b0);
        chk("post_err", dm_err,    1'b0);
        chk("post_bcdt", dm_bc_dt, exp_bc_dt);
    endtask

    initial begin
        logic [15:0] bb_dt [3];
        bit          r_rd;
        logic [15:0] r_addr;
        logic [15:0] r_data;
        int          r_wait;

        bb_dt[0] = 16'h1111;
        bb_dt[1] = 16'h2222;
        bb_dt[2] = 16'h3333;

        rst_n     = 1'b0;
        ps_dm_rd  = 1'b0;
        ps_dm_wrt = 1'b0;
        dg_dm_add = 16'h0000;
        bc_dt     = 16'h0000;
        dm_rdy    = 1'b0;
        dm_rd_dt  = 16'h0000;
        repeat (3) @(posedge clk_rf);
        #1;
        chk_zero("rst");
        rst_n = 1'b1;
        tick();
        chk_zero("rst_rel");

        // Zero-wait read, 3-wait write, timeouts and the longest legal wait.
        run_access(1'b1, 16'h0040, 16'h1234, 0);
        run_access(1'b0, 16'h00A5, 16'hBEEF, 3);
        run_access(1'b1, 16'h0123, 16'hCAFE, TMO + 1);
        run_access(1'b0, 16'h0456, 16'hD00D, TMO + 4);
        run_access(1'b1, 16'h0789, 16'h5A5A, TMO);

        // Back-to-back reads at 1, 2, 3 with the memory always ready.
        $display("txn b2b reads addr=0001..0003");
        ps_dm_rd  = 1'b1;
        ps_dm_wrt = 1'b0;
        dg_dm_add = 16'h0001;
        dm_rdy    = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("b2b_add",  dm_add,   16'(i + 1));
            chk("b2b_rden", dm_rd_en, 1'b1);
            if (i > 0) begin
                chk("b2b_vld",  dm_bc_vld, 1'b1);
                chk("b2b_bcdt", dm_bc_dt,  bb_dt[i-1]);
            end else begin
                chk("b2b_vld0", dm_bc_vld, 1'b0);
            end
            dm_rd_dt = bb_dt[i];
            if (i < 2) dg_dm_add = 16'(i + 2);
            else       ps_dm_rd  = 1'b0;
            #1;
            chk("b2b_stall", dm_ps_stall, 1'b0);
            tick();
        end
        exp_bc_dt = 16'h3333;
        chk("b2b_last_vld",  dm_bc_vld, 1'b1);
        chk("b2b_last_bcdt", dm_bc_dt,  exp_bc_dt);
        chk("b2b_last_rden", dm_rd_en,  1'b0);
        dm_rdy = 1'b0;
        tick();
        chk("b2b_post_vld", dm_bc_vld, 1'b0);

        // Illegal command in IDLE.
        $display("txn illegal in idle");
        ps_dm_rd  = 1'b1;
        ps_dm_wrt = 1'b1;
        dg_dm_add = 16'h0BAD;
        tick();
        chk("ill_rden",  dm_rd_en,    1'b0);
        chk("ill_wren",  dm_wrt_en,   1'b0);
        chk("ill_err",   dm_err,      1'b1);
        chk("ill_vld",   dm_bc_vld,   1'b0);
        ps_dm_rd  = 1'b0;
        ps_dm_wrt = 1'b0;
        #1;
        chk("ill_stall", dm_ps_stall, 1'b0);
        tick();
        chk("ill_err_pulse", dm_err, 1'b0);
        chk("ill_add_held",  dm_add, 16'h0003);

        // Illegal command arriving in the completing cycle of a read.
        $display("txn read then illegal on completion");
        ps_dm_rd  = 1'b1;
        dg_dm_add = 16'h0077;
        dm_rdy    = 1'b1;
        tick();
        ps_dm_wrt = 1'b1;
        dm_rd_dt  = 16'h5555;
        tick();
        exp_bc_dt = 16'h5555;
        chk("illc_vld",  dm_bc_vld, 1'b1);
        chk("illc_bcdt", dm_bc_dt,  exp_bc_dt);
        chk("illc_err",  dm_err,    1'b1);
        chk("illc_rden", dm_rd_en,  1'b0);
        chk("illc_wren", dm_wrt_en, 1'b0);
        ps_dm_rd  = 1'b0;
        ps_dm_wrt = 1'b0;
        dm_rdy    = 1'b0;
        tick();
        chk("illc_err_pulse", dm_err,      1'b0);
        chk("illc_idle",      dm_ps_stall, 1'b0);

        // Reset during the second wait cycle of a write.
        $display("txn write reset mid-wait");
        ps_dm_wrt = 1'b1;
        dg_dm_add = 16'h0300;
        bc_dt     = 16'h7777;
        dm_rdy    = 1'b0;
        tick();
        ps_dm_wrt = 1'b0;
        tick();
        chk("mid_stall", dm_ps_stall, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        exp_bc_dt  = 16'h0000;
        exp_wrt_dt = 16'h0000;
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rel_vld", dm_bc_vld, 1'b0);
        chk("mid_rel_err", dm_err,    1'b0);
        run_access(1'b1, 16'h0010, 16'hA5A5, 0);

        // Randomized isolated accesses, occasionally timing out.
        for (int i = 0; i < 24; i++) begin
            r_rd   = 1'($urandom_range(0, 1));
            r_addr = 16'($urandom);
            r_data = 16'($urandom);
            r_wait = ($urandom_range(0, 7) == 7) ? int'($urandom_range(TMO + 1, TMO + 3))
                                                 : int'($urandom_range(0, 4));
            run_access(r_rd, r_addr, r_data, r_wait);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dm_acc_ctl.md
# dm_acc_ctl

Data-memory access controller sitting directly downstream of the data address generator. It takes the generated DM address (`dg_dm_add`) plus a read/write command from the program sequencer, and drives a single-port data memory that may insert wait states. Read data is returned to the bus-connect path. The sequencer is stalled while an access is outstanding, and a wait-state timeout aborts hung accesses with an error pulse.

## Interface
- `TMO`, default 15: maximum wait count (0..15); an access aborts after TMO+1 consecutive not-ready cycles.
- `clk_rf  in  1`: clock; all state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `ps_dm_rd  in  1`: sequencer read command; sampled only while `dm_ps_stall`=0.
- `ps_dm_wrt  in  1`: sequencer write command; sampled only while `dm_ps_stall`=0.
- `dg_dm_add  in  16`: DM address from the DAG, valid with the command.
- `bc_dt  in  16`: write data from bus connect, valid with `ps_dm_wrt`.
- `dm_rdy  in  1`: memory ready; the access completes in a REQ cycle where this is 1.
- `dm_rd_dt  in  16`: memory read data, valid when `dm_rdy`=1 during a read.
- `dm_add  out  16`: registered memory address.
- `dm_wrt_dt  out  16`: registered memory write data.
- `dm_rd_en  out  1`: registered read strobe.
- `dm_wrt_en  out  1`: registered write strobe.
- `dm_bc_dt  out  16`: read data returned to bus connect; holds its value between reads.
- `dm_bc_vld  out  1`: one-cycle pulse when `dm_bc_dt` is updated.
- `dm_ps_stall  out  1`: sequencer stall; commands must be held stable while it is 1.
- `dm_err  out  1`: one-cycle error pulse (timeout or illegal command).

## Operation
- States: IDLE and REQ. Internal registers: `op` (rd/wr), 4-bit wait counter `wcnt`.
- **Reset:** state=IDLE, `wcnt`=0, and all outputs 0 (`dm_add`, `dm_wrt_dt`, `dm_bc_dt`=16'h0000; all strobes and pulses 0).
- **Accept.** A command is accepted on any edge where `dm_ps_stall`=0 and exactly one of `ps_dm_rd`/`ps_dm_wrt` is 1. On accept:
  - `dm_add` ← `dg_dm_add`; `dm_wrt_dt` ← `bc_dt` (writes only; otherwise held).
  - The matching strobe is set and the other cleared; `wcnt` ← 0; state ← REQ.
- **IDLE:** strobes are 0. With no command, remain in IDLE.
- **REQ with `dm_rdy`=1.** The access completes.
  - On a read: `dm_bc_dt` ← `dm_rd_dt` and `dm_bc_vld` ← 1 at the next edge.
  - If a new legal command is present in the same cycle (stall is 0), accept it at that edge and stay in REQ (back-to-back).
  - Otherwise clear the strobes and go to IDLE.
- **REQ with `dm_rdy`=0 and `wcnt` < TMO:** `wcnt` ← `wcnt`+1; outputs are held.
- **REQ with `dm_rdy`=0 and `wcnt`=TMO:** abort.
  - Clear the strobes, go to IDLE, and pulse `dm_err`.
  - If the aborted access was a read, also `dm_bc_dt` ← 16'h0000 and `dm_bc_vld` ← 1.
- **Illegal command.** `ps_dm_rd`=`ps_dm_wrt`=1 while stall=0 is not accepted.
  - `dm_err` pulses at the next edge.
  - If this occurs in a completing REQ cycle, the FSM goes to IDLE.
- `dm_ps_stall` = (state==REQ) & ~`dm_rdy` (combinational). It is 0 in IDLE.
- Addresses and data pass through unmodified; no arithmetic beyond `wcnt`, which never wraps (bounded by TMO).

## Timing
- Zero-wait access: accept at edge 0; strobe high in cycle 1; read data on `dm_bc_dt` with `dm_bc_vld`=1 in cycle 2. No stall.
- N wait states: stall is high for N cycles; read data is valid 2+N cycles after accept.
- Sustained throughput: one access per cycle when `dm_rdy` stays 1.
- Abort timing: a timeout abort occurs at the end of the (TMO+1)-th not-ready REQ cycle; `dm_err` is high in the following cycle.
- Reset mid-access: immediate return to reset values; the pending access is dropped with no `dm_err` and no `dm_bc_vld`.
- `dm_bc_vld` and `dm_err` are never high for more than one consecutive cycle per event.

## Test plan
- **Zero-wait read:** `ps_dm_rd`=1, `dg_dm_add`=0x0040, `dm_rdy`=1, `dm_rd_dt`=0x1234 → `dm_rd_en`=1 with `dm_add`=0x0040 in cycle 1; `dm_bc_dt`=0x1234 and `dm_bc_vld`=1 in cycle 2; stall never 1.
- **3-wait write:** `ps_dm_wrt`=1, addr 0x00A5, `bc_dt`=0xBEEF, `dm_rdy` low for 3 REQ cycles → `dm_wrt_en`=1 for 4 cycles; stall high for exactly 3 cycles; no `dm_bc_vld`.
- **Back-to-back reads:** reads at 0x0001, 0x0002, 0x0003 on consecutive cycles with `dm_rdy`=1 → `dm_add` steps 1, 2, 3 on consecutive cycles; three consecutive `dm_bc_vld` pulses with matching data; FSM never visits IDLE between them.
- **Timeout (TMO=15):** read with `dm_rdy` held 0 → stall high for 16 cycles; then `dm_err`=1, `dm_bc_vld`=1, `dm_bc_dt`=0x0000, `dm_rd_en`=0, state IDLE.
- **Illegal command:** `ps_dm_rd`=`ps_dm_wrt`=1 in IDLE → no strobe asserted; `dm_err` one-cycle pulse; state IDLE.
- **Reset mid-wait:** deassert `rst_n` during the 2nd wait cycle of a write → all outputs 0 immediately; after release, a new read at 0x0010 completes normally.
